// File: rtl/display_scanner.sv
// Multiplexed seven-segment scanner: shadow/display double buffer swapped at frame
// boundaries, leading-zero blanking, per-digit blink and a dead cycle at each slot start.
module display_scanner #(
    parameter int DIGITS       = 4,
    parameter int SIZE         = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIGITS*SIZE-1:0]   din,
    input  logic                     load,
    input  logic                     blank_lz,
    input  logic                     blink_en,
    input  logic [DIGITS-1:0]        blink_mask,
    output logic [6:0]               seg,
    output logic [DIGITS-1:0]        an,
    output logic                     frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]          presc_reg, presc_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic [DIGITS*SIZE-1:0] shadow_reg, shadow_next;
    logic [DIGITS*SIZE-1:0] display_reg, display_next;
    logic [BW-1:0]          blink_cnt_reg, blink_cnt_next;
    logic                   phase_reg, phase_next;
    logic [6:0]             seg_reg, seg_next;
    logic [DIGITS-1:0]      an_reg, an_next;
    logic                   frame_tick_reg, frame_tick_next;

    logic                   slot_end;
    logic                   frame_end;
    logic [DIGITS-1:0]      digit_zero;
    logic [DIGITS-1:0]      zero_above;
    logic [6:0]             digit_seg [DIGITS];
    logic [6:0]             sel_seg;

    function automatic logic [6:0] decode7(input logic [SIZE-1:0] v);
        logic [6:0] s;
        case (32'(v))
            32'd0:   s = 7'b1111110;
            32'd1:   s = 7'b0110000;
            32'd2:   s = 7'b1101101;
            32'd3:   s = 7'b1111001;
            32'd4:   s = 7'b0110011;
            32'd5:   s = 7'b1011011;
            32'd6:   s = 7'b1011111;
            32'd7:   s = 7'b1110000;
            32'd8:   s = 7'b1111111;
            32'd9:   s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Digit k counts as a leading zero only if it and every more significant digit is zero.
    always_comb begin
        zero_above             = '0;
        zero_above[DIGITS-1]   = digit_zero[DIGITS-1];
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zero_above[k] = digit_zero[k] & zero_above[k+1];
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [SIZE-1:0] val;
            logic            lz_blank;
            logic            blink_blank;

            assign val            = display_reg[gi*SIZE +: SIZE];
            assign digit_zero[gi] = (val == '0);
            assign blink_blank    = blink_en & blink_mask[gi] & phase_reg;

            if (gi == 0) begin : g_units
                assign lz_blank = 1'b0;
            end else begin : g_upper
                assign lz_blank = blank_lz & zero_above[gi];
            end

            assign digit_seg[gi] = (lz_blank | blink_blank) ? 7'b0000000 : decode7(val);
        end
    endgenerate

    assign slot_end  = (presc_reg == PRESC_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    always_comb begin
        presc_next      = presc_reg + PW'(1);
        idx_next        = idx_reg;
        shadow_next     = shadow_reg;
        display_next    = display_reg;
        blink_cnt_next  = blink_cnt_reg;
        phase_next      = phase_reg;
        frame_tick_next = frame_end;
        sel_seg         = 7'b0000000;
        seg_next        = 7'b0000000;
        an_next         = '1;

        if (slot_end) begin
            presc_next = '0;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end

        if (load) begin
            shadow_next = din;
        end

        // The display buffer only changes between frames, so a frame never tears.
        if (frame_end) begin
            display_next = shadow_reg;
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_next = '0;
                phase_next     = ~phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + BW'(1);
            end
        end

        for (int k = 0; k < DIGITS; k++) begin
            if (idx_reg == IW'(k)) begin
                sel_seg = digit_seg[k];
            end
        end

        // First cycle of every slot is dead time: all digits off to avoid ghosting.
        if (presc_reg != '0) begin
            seg_next = sel_seg;
            an_next  = ~(DIGITS'(1) << idx_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg      <= '0;
            idx_reg        <= '0;
            shadow_reg     <= '0;
            display_reg    <= '0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            seg_reg        <= 7'b0000000;
            an_reg         <= '1;
            frame_tick_reg <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            idx_reg        <= idx_next;
            shadow_reg     <= shadow_next;
            display_reg    <= display_next;
            blink_cnt_reg  <= blink_cnt_next;
            phase_reg      <= phase_next;
            seg_reg        <= seg_next;
            an_reg         <= an_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule
